// File: rtl/gpu_block_dispatcher_if.sv
// rtl/gpu_block_dispatcher_if.sv - launch control and per-core start/done bundle for the block dispatcher
interface gpu_block_dispatcher_if #(
    parameter int NUM_CORES = 4,
    parameter int TC_BITS   = 8
);
    logic                         start;
    logic [TC_BITS-1:0]           thread_count;
    logic [NUM_CORES-1:0]         core_done;
    logic [NUM_CORES-1:0]         core_start;
    logic [NUM_CORES*TC_BITS-1:0] core_block_id;
    logic [NUM_CORES*TC_BITS-1:0] core_thread_count;
    logic                         busy;
    logic                         done;

    modport master (
        input  start, thread_count, core_done,
        output core_start, core_block_id, core_thread_count, busy, done
    );

    modport slave (
        output start, thread_count, core_done,
        input  core_start, core_block_id, core_thread_count, busy, done
    );
endinterface

// File: rtl/gpu_block_dispatcher.sv
// rtl/gpu_block_dispatcher.sv - splits a launch into thread blocks and dispatches them to N cores
module gpu_block_dispatcher #(
    parameter int NUM_CORES         = 4,
    parameter int THREADS_PER_BLOCK = 4,
    parameter int TC_BITS           = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    gpu_block_dispatcher_if.master bus
);
    localparam int CW       = TC_BITS + 1;
    localparam int TPB_LOG2 = $clog2(THREADS_PER_BLOCK);
    localparam logic [CW-1:0] TPB_W  = CW'(THREADS_PER_BLOCK);
    localparam logic [CW-1:0] TPB_M1 = CW'(THREADS_PER_BLOCK - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e                       state_q, state_d;
    logic [TC_BITS-1:0]           tc_q, tc_d;
    logic [CW-1:0]                total_blocks_q, total_blocks_d;
    logic [CW-1:0]                next_block_q, next_block_d;
    logic [CW-1:0]                blocks_done_q, blocks_done_d;
    logic [NUM_CORES-1:0]         core_busy_q, core_busy_d;
    logic [NUM_CORES-1:0]         core_start_q, core_start_d;
    logic [NUM_CORES*TC_BITS-1:0] block_id_q, block_id_d;
    logic [NUM_CORES*TC_BITS-1:0] thr_cnt_q, thr_cnt_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;

    logic [NUM_CORES-1:0] done_hits;
    logic [NUM_CORES-1:0] free_cores;
    logic [NUM_CORES-1:0] pick_oh;
    int                   pick_idx;
    logic [CW-1:0]        hit_cnt;
    logic [CW-1:0]        offset_w;
    logic [CW-1:0]        remaining_w;
    logic [CW-1:0]        blk_cnt_w;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            tc_q           <= '0;
            total_blocks_q <= '0;
            next_block_q   <= '0;
            blocks_done_q  <= '0;
            core_busy_q    <= '0;
            core_start_q   <= '0;
            block_id_q     <= '0;
            thr_cnt_q      <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            tc_q           <= tc_d;
            total_blocks_q <= total_blocks_d;
            next_block_q   <= next_block_d;
            blocks_done_q  <= blocks_done_d;
            core_busy_q    <= core_busy_d;
            core_start_q   <= core_start_d;
            block_id_q     <= block_id_d;
            thr_cnt_q      <= thr_cnt_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    // A core finishing this cycle is not eligible until the next one.
    always_comb begin
        done_hits  = bus.core_done & core_busy_q;
        free_cores = ~core_busy_q & ~bus.core_done;
        pick_oh    = free_cores & (~free_cores + NUM_CORES'(1));
        pick_idx   = 0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (free_cores[i]) pick_idx = i;
        end
        hit_cnt = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            hit_cnt = hit_cnt + CW'(done_hits[i]);
        end
        offset_w    = next_block_q << TPB_LOG2;
        remaining_w = {1'b0, tc_q} - offset_w;
        blk_cnt_w   = (remaining_w < TPB_W) ? remaining_w : TPB_W;
    end

    always_comb begin
        tc_d           = tc_q;
        total_blocks_d = total_blocks_q;
        next_block_d   = next_block_q;
        blocks_done_d  = blocks_done_q;
        core_busy_d    = core_busy_q;
        core_start_d   = '0;
        block_id_d     = block_id_q;
        thr_cnt_d      = thr_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    tc_d           = bus.thread_count;
                    total_blocks_d = ({1'b0, bus.thread_count} + TPB_M1) >> TPB_LOG2;
                    next_block_d   = '0;
                    blocks_done_d  = '0;
                    core_busy_d    = '0;
                end
            end
            S_RUN: begin
                blocks_done_d = blocks_done_q + hit_cnt;
                core_busy_d   = core_busy_q & ~done_hits;
                if ((next_block_q < total_blocks_q) && (|free_cores)) begin
                    core_start_d = pick_oh;
                    core_busy_d  = core_busy_d | pick_oh;
                    block_id_d[pick_idx*TC_BITS +: TC_BITS] = next_block_q[TC_BITS-1:0];
                    thr_cnt_d[pick_idx*TC_BITS +: TC_BITS]  = blk_cnt_w[TC_BITS-1:0];
                    next_block_d = next_block_q + CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.start) state_d = (bus.thread_count == '0) ? S_DONE : S_RUN;
            S_RUN:  if (blocks_done_d == total_blocks_q) state_d = S_DONE;
            S_DONE: if (!bus.start) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_d = (state_q == S_RUN);
        done_d = (state_q == S_DONE);
    end

    assign bus.core_start        = core_start_q;
    assign bus.core_block_id     = block_id_q;
    assign bus.core_thread_count = thr_cnt_q;
    assign bus.busy              = busy_q;
    assign bus.done              = done_q;
endmodule

// File: tb/tb_gpu_block_dispatcher.sv
// tb/tb_gpu_block_dispatcher.sv - directed self-checking bench for gpu_block_dispatcher
module tb_gpu_block_dispatcher;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [3:0] seen;

    always #5 clk = ~clk;

    gpu_block_dispatcher_if #(.NUM_CORES(4), .TC_BITS(8)) bus();

    gpu_block_dispatcher #(.NUM_CORES(4), .THREADS_PER_BLOCK(4), .TC_BITS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [7:0] id_of(input int i);
        return bus.core_block_id[i*8 +: 8];
    endfunction

    function automatic logic [7:0] cnt_of(input int i);
        return bus.core_thread_count[i*8 +: 8];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
        seen = seen | bus.core_start;
    endtask

    task automatic launch(input logic [7:0] tc);
        bus.thread_count = tc;
        bus.start        = 1'b1;
        seen             = '0;
        tick();
    endtask

    task automatic finish_launch(input string name);
        bus.start = 1'b0;
        tick();
        tick();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL %s_done_clear: got %b expected 0", name, bus.done); end
    endtask

    task automatic test_reset;
        bus.start = 1'b0; bus.thread_count = '0; bus.core_done = '0; seen = '0;
        tick(); tick();
        checks++; if (bus.core_start !== 4'b0) begin errors++; $display("FAIL reset_core_start: got %b expected 0", bus.core_start); end
        checks++; if ({bus.busy, bus.done} !== 2'b00) begin errors++; $display("FAIL reset_busy_done: got %b expected 00", {bus.busy, bus.done}); end
        checks++; if ({bus.core_block_id, bus.core_thread_count} !== 64'd0) begin errors++; $display("FAIL reset_ids: got %h expected 0", {bus.core_block_id, bus.core_thread_count}); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_two_blocks;
        launch(8'd8);
        checks++; if ({bus.core_start, bus.busy} !== 5'b0) begin errors++; $display("FAIL t1_first_cycle: got %b expected 0", {bus.core_start, bus.busy}); end
        tick();
        checks++; if (bus.core_start !== 4'b0001 || id_of(0) !== 8'd0 || cnt_of(0) !== 8'd4) begin errors++; $display("FAIL t1_core0: start %b id %0d cnt %0d expected 0001/0/4", bus.core_start, id_of(0), cnt_of(0)); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL t1_busy: got %b expected 1", bus.busy); end
        tick();
        checks++; if (bus.core_start !== 4'b0010 || id_of(1) !== 8'd1 || cnt_of(1) !== 8'd4) begin errors++; $display("FAIL t1_core1: start %b id %0d cnt %0d expected 0010/1/4", bus.core_start, id_of(1), cnt_of(1)); end
        tick();
        bus.core_done = 4'b0001; tick();
        bus.core_done = 4'b0010; tick();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL t1_done_early: got %b expected 0", bus.done); end
        bus.core_done = 4'b0000; tick();
        checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL t1_done: done %b busy %b expected 1/0", bus.done, bus.busy); end
        checks++; if (seen !== 4'b0011) begin errors++; $display("FAIL t1_cores_used: got %b expected 0011", seen); end
        finish_launch("t1");
    endtask

    task automatic test_tail_block;
        launch(8'd18);
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++; if (bus.core_start !== 4'(1 << c) || id_of(c) !== 8'(c) || cnt_of(c) !== 8'd4) begin errors++; $display("FAIL t2_core%0d: start %b id %0d cnt %0d expected %b/%0d/4", c, bus.core_start, id_of(c), cnt_of(c), 4'(1 << c), c); end
        end
        bus.core_done = 4'b0001; tick();
        checks++; if (bus.core_start !== 4'b0000) begin errors++; $display("FAIL t2_no_same_cycle_redispatch: got %b expected 0000", bus.core_start); end
        bus.core_done = 4'b0000; tick();
        checks++; if (bus.core_start !== 4'b0001 || id_of(0) !== 8'd4 || cnt_of(0) !== 8'd2) begin errors++; $display("FAIL t2_tail: start %b id %0d cnt %0d expected 0001/4/2", bus.core_start, id_of(0), cnt_of(0)); end
        bus.core_done = 4'b1110; tick();
        bus.core_done = 4'b0001; tick();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL t2_done_early: got %b expected 0", bus.done); end
        bus.core_done = 4'b0000; tick();
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL t2_done: got %b expected 1", bus.done); end
        finish_launch("t2");
    endtask

    task automatic test_zero_threads;
        launch(8'd0);
        checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL t3_edge1: done %b busy %b expected 0/0", bus.done, bus.busy); end
        tick();
        checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL t3_edge2: done %b busy %b expected 1/0", bus.done, bus.busy); end
        tick();
        checks++; if (seen !== 4'b0000) begin errors++; $display("FAIL t3_no_start: got %b expected 0000", seen); end
        finish_launch("t3");
    endtask

    task automatic test_simultaneous_done;
        launch(8'd24);
        tick(); tick(); tick(); tick();
        bus.core_done = 4'b1010; tick();
        checks++; if (bus.core_start !== 4'b0000) begin errors++; $display("FAIL t4_excluded: got %b expected 0000", bus.core_start); end
        bus.core_done = 4'b0000; tick();
        checks++; if (bus.core_start !== 4'b0010 || id_of(1) !== 8'd4 || cnt_of(1) !== 8'd4) begin errors++; $display("FAIL t4_core1: start %b id %0d cnt %0d expected 0010/4/4", bus.core_start, id_of(1), cnt_of(1)); end
        tick();
        checks++; if (bus.core_start !== 4'b1000 || id_of(3) !== 8'd5 || cnt_of(3) !== 8'd4) begin errors++; $display("FAIL t4_core3: start %b id %0d cnt %0d expected 1000/5/4", bus.core_start, id_of(3), cnt_of(3)); end
        bus.core_done = 4'b0100; tick();
        bus.core_done = 4'b0100; tick();
        bus.core_done = 4'b0001; tick();
        bus.core_done = 4'b0010; tick();
        bus.core_done = 4'b0000; tick();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL t4_spurious_counted: done %b expected 0", bus.done); end
        bus.core_done = 4'b1000; tick();
        bus.core_done = 4'b0000; tick();
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL t4_done: got %b expected 1", bus.done); end
        finish_launch("t4");
    endtask

    task automatic test_reset_mid_run;
        launch(8'd18);
        tick(); tick(); tick(); tick();
        bus.core_done = 4'b0011; tick();
        bus.core_done = 4'b0000; tick();
        checks++; if (bus.core_start !== 4'b0001) begin errors++; $display("FAIL t5_pre_reset: got %b expected 0001", bus.core_start); end
        #2 reset = 1'b0; bus.start = 1'b0;
        #1;
        checks++; if ({bus.core_start, bus.busy, bus.done} !== 6'b0) begin errors++; $display("FAIL t5_async_clear: got %b expected 0", {bus.core_start, bus.busy, bus.done}); end
        checks++; if ({bus.core_block_id, bus.core_thread_count} !== 64'd0) begin errors++; $display("FAIL t5_ids_clear: got %h expected 0", {bus.core_block_id, bus.core_thread_count}); end
        tick(); tick();
        reset = 1'b1;
        tick();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL t5_no_done_after_abort: got %b expected 0", bus.done); end
        launch(8'd4);
        tick();
        checks++; if (bus.core_start !== 4'b0001 || id_of(0) !== 8'd0 || cnt_of(0) !== 8'd4) begin errors++; $display("FAIL t5_relaunch: start %b id %0d cnt %0d expected 0001/0/4", bus.core_start, id_of(0), cnt_of(0)); end
        bus.core_done = 4'b0001; tick();
        bus.core_done = 4'b0000; tick();
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL t5_done: got %b expected 1", bus.done); end
        finish_launch("t5");
    endtask

    task automatic test_max_count;
        int starts = 0;
        int bad = 0;
        int last_id = -1;
        int last_cnt = -1;
        int exp_cnt;
        int idx;
        launch(8'd255);
        for (int t = 0; t < 400 && !bus.done; t++) begin
            tick();
            if (bus.core_start != 4'b0) begin
                idx = 0;
                for (int i = 3; i >= 0; i--) if (bus.core_start[i]) idx = i;
                if ($countones(bus.core_start) != 1) bad++;
                exp_cnt = (starts == 63) ? 3 : 4;
                if (int'(id_of(idx)) != starts || int'(cnt_of(idx)) != exp_cnt) bad++;
                last_id  = int'(id_of(idx));
                last_cnt = int'(cnt_of(idx));
                starts++;
            end
            bus.core_done = bus.core_start;
        end
        bus.core_done = 4'b0000;
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL t6_timeout: done %b expected 1 within budget", bus.done); end
        checks++; if (starts != 64 || bad != 0) begin errors++; $display("FAIL t6_dispatches: starts %0d bad %0d expected 64/0", starts, bad); end
        checks++; if (last_id != 63 || last_cnt != 3) begin errors++; $display("FAIL t6_last_block: id %0d cnt %0d expected 63/3", last_id, last_cnt); end
        tick(); tick(); tick();
        checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.core_start !== 4'b0) begin errors++; $display("FAIL t6_hold: done %b busy %b start %b expected 1/0/0000", bus.done, bus.busy, bus.core_start); end
        finish_launch("t6");
    endtask

    initial begin
        test_reset();
        test_two_blocks();
        test_tail_block();
        test_zero_threads();
        test_simultaneous_done();
        test_reset_mid_run();
        test_max_count();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
